// File: rtl/axil_uart_regs_if.sv
// axil_uart_regs_if: AXI4-Lite bus bundle between a master and axil_uart_regs.
interface axil_uart_regs_if #(
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic                            S_AXI_AWVALID;
  logic                            S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                            S_AXI_WVALID;
  logic                            S_AXI_WREADY;
  logic [1:0]                      S_AXI_BRESP;
  logic                            S_AXI_BVALID;
  logic                            S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic                            S_AXI_ARVALID;
  logic                            S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]                      S_AXI_RRESP;
  logic                            S_AXI_RVALID;
  logic                            S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/axil_uart_regs.sv
// axil_uart_regs: AXI4-Lite register front end for a UART with TX and RX FIFOs.
// Map: 0x0 RXFIFO (rd), 0x4 TXFIFO (wr), 0x8 STAT (rd), 0xC CTRL (wr).
// Define AXIL_UART_IRQ_EN to build the interrupt enable and pulse logic.
module axil_uart_regs #(
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_DATA_BITS        = 8,
  parameter int unsigned C_TX_FIFO_DEPTH    = 16,
  parameter int unsigned C_RX_FIFO_DEPTH    = 16
) (
  input  logic                   S_AXI_ACLK,
  input  logic                   S_AXI_ARESETN,
  axil_uart_regs_if.slave        s_axi,
  output logic [C_DATA_BITS-1:0] TX_DATA,
  output logic                   TX_VALID,
  input  logic                   TX_READY,
  input  logic [C_DATA_BITS-1:0] RX_DATA,
  input  logic                   RX_VALID,
  output logic                   Interrupt
);
  localparam int unsigned TAW = $clog2(C_TX_FIFO_DEPTH);
  localparam int unsigned RAW = $clog2(C_RX_FIFO_DEPTH);
  localparam int unsigned DW  = C_S_AXI_DATA_WIDTH;

  logic                   awready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0]             bresp_q, rresp_q;
  logic [DW-1:0]          rdata_q;
  logic [C_DATA_BITS-1:0] tx_mem [C_TX_FIFO_DEPTH];
  logic [C_DATA_BITS-1:0] rx_mem [C_RX_FIFO_DEPTH];
  logic [TAW:0]           tx_wptr_q, tx_rptr_q;
  logic [RAW:0]           rx_wptr_q, rx_rptr_q;
  logic                   overrun_q, irq_en;

  logic          wr_hs, rd_hs;
  logic [1:0]    wr_sel, rd_sel;
  logic          tx_empty, tx_full, rx_empty, rx_full;
  logic          tx_push_req, tx_push, tx_pop, tx_flush;
  logic          rx_push, rx_pop, rx_flush, ovr_set, stat_rd;
  logic [DW-1:0] rd_word;
  logic [1:0]    rd_resp;
  logic          unused_bits;

  assign wr_hs  = awready_q & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
  assign rd_hs  = arready_q & s_axi.S_AXI_ARVALID;
  assign wr_sel = s_axi.S_AXI_AWADDR[3:2];
  assign rd_sel = s_axi.S_AXI_ARADDR[3:2];

  // Extra MSB distinguishes full from empty when the index bits match.
  assign tx_empty = (tx_wptr_q == tx_rptr_q);
  assign tx_full  = (tx_wptr_q[TAW] != tx_rptr_q[TAW]) &&
                    (tx_wptr_q[TAW-1:0] == tx_rptr_q[TAW-1:0]);
  assign rx_empty = (rx_wptr_q == rx_rptr_q);
  assign rx_full  = (rx_wptr_q[RAW] != rx_rptr_q[RAW]) &&
                    (rx_wptr_q[RAW-1:0] == rx_rptr_q[RAW-1:0]);

  assign tx_push_req = wr_hs && (wr_sel == 2'd1) && s_axi.S_AXI_WSTRB[0];
  assign tx_push     = tx_push_req && !tx_full;
  assign tx_pop      = !tx_empty && TX_READY;
  assign tx_flush    = wr_hs && (wr_sel == 2'd3) && s_axi.S_AXI_WDATA[0];
  assign rx_flush    = wr_hs && (wr_sel == 2'd3) && s_axi.S_AXI_WDATA[1];
  assign rx_pop      = rd_hs && (rd_sel == 2'd0) && !rx_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign rx_push     = RX_VALID && (!rx_full || rx_pop);
  assign ovr_set     = RX_VALID && rx_full && !rx_pop;
  assign stat_rd     = rd_hs && (rd_sel == 2'd2);

  assign TX_VALID = !tx_empty;
  assign TX_DATA  = tx_mem[tx_rptr_q[TAW-1:0]];

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = awready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;

  assign unused_bits = ^{s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB, s_axi.S_AXI_AWADDR,
                         s_axi.S_AXI_ARADDR};

  // Read data/response selected at the AR handshake.
  always_comb begin
    rd_word = '0;
    rd_resp = 2'b00;
    case (rd_sel)
      2'd0: begin
        if (!rx_empty) rd_word[C_DATA_BITS-1:0] = rx_mem[rx_rptr_q[RAW-1:0]];
        else           rd_resp = 2'b10;
      end
      2'd2:    rd_word[5:0] = {overrun_q, irq_en, tx_full, tx_empty, rx_full, !rx_empty};
      default: ;
    endcase
  end

  // Write channel: one-cycle AW/W ready pulse, response held until BREADY.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
    end else begin
      awready_q <= s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID && !bvalid_q && !awready_q;
      if (wr_hs) begin
        bvalid_q <= 1'b1;
        bresp_q  <= (tx_push_req && tx_full) ? 2'b10 : 2'b00;
      end else if (bvalid_q && s_axi.S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Read channel: one-cycle AR ready pulse, data held until RREADY.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
    end else begin
      arready_q <= s_axi.S_AXI_ARVALID && !rvalid_q && !arready_q;
      if (rd_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_word;
        rresp_q  <= rd_resp;
      end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // TX FIFO pointers; flush wins over any push/pop in the same cycle.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
    end else if (tx_flush) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + {{TAW{1'b0}}, 1'b1};
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + {{TAW{1'b0}}, 1'b1};
    end
  end

  // TX FIFO storage.
  always_ff @(posedge S_AXI_ACLK) begin
    if (tx_push) tx_mem[tx_wptr_q[TAW-1:0]] <= s_axi.S_AXI_WDATA[C_DATA_BITS-1:0];
  end

  // RX FIFO pointers; flush wins over any push/pop in the same cycle.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
    end else if (rx_flush) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
    end else begin
      if (rx_push) rx_wptr_q <= rx_wptr_q + {{RAW{1'b0}}, 1'b1};
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + {{RAW{1'b0}}, 1'b1};
    end
  end

  // RX FIFO storage.
  always_ff @(posedge S_AXI_ACLK) begin
    if (rx_push) rx_mem[rx_wptr_q[RAW-1:0]] <= RX_DATA;
  end

  // Sticky overrun; a new drop outranks the clear-on-STAT-read.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN)  overrun_q <= 1'b0;
    else if (ovr_set)    overrun_q <= 1'b1;
    else if (stat_rd)    overrun_q <= 1'b0;
  end

`ifdef AXIL_UART_IRQ_EN
  logic irq_en_q, irq_q, rx_empty_q, tx_empty_q;

  // CTRL[4] is the only persistent control bit.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN)                   irq_en_q <= 1'b0;
    else if (wr_hs && (wr_sel == 2'd3))   irq_en_q <= s_axi.S_AXI_WDATA[4];
  end

  // Edge-detect FIFO occupancy and register a single-cycle pulse.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rx_empty_q <= 1'b1;
      tx_empty_q <= 1'b1;
      irq_q      <= 1'b0;
    end else begin
      rx_empty_q <= rx_empty;
      tx_empty_q <= tx_empty;
      irq_q      <= irq_en_q && ((rx_empty_q && !rx_empty) || (!tx_empty_q && tx_empty));
    end
  end

  assign irq_en    = irq_en_q;
  assign Interrupt = irq_q;
`else
  assign irq_en    = 1'b0;
  assign Interrupt = 1'b0;
`endif
endmodule
